md5_arbiter: RTL and testbench

MD5_ARBITER -- requirements
Module: md5_arbiter

---
 rtl/md5_arbiter_if.sv | 34 +++
 rtl/md5_arbiter.sv | 149 ++++++++++++++
 tb/tb_md5_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_arbiter_if.sv
// Requester / hash-core / response bus of the MD5 arbiter.
// master: the arbiter itself; slave: whatever drives requests and models the core.
interface md5_arbiter_if;
    logic [3:0]   req;
    logic [511:0] req_msg;
    logic [31:0]  req_width;
    logic [3:0]   req_ack;
    logic [127:0] core_msg_in;
    logic [7:0]   core_msg_width;
    logic         core_msg_valid;
    logic         core_ready;
    logic [127:0] core_msg_out;
    logic         core_out_valid;
    logic [127:0] target;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_digest;
    logic         match;
    logic [1:0]   match_id;
    logic         err;
    logic         busy;

    modport master (
        input  req, req_msg, req_width, core_ready, core_msg_out, core_out_valid, target,
        output req_ack, core_msg_in, core_msg_width, core_msg_valid,
               rsp_valid, rsp_id, rsp_digest, match, match_id, err, busy
    );

    modport slave (
        output req, req_msg, req_width, core_ready, core_msg_out, core_out_valid, target,
        input  req_ack, core_msg_in, core_msg_width, core_msg_valid,
               rsp_valid, rsp_id, rsp_digest, match, match_id, err, busy
    );
endinterface

// File: rtl/md5_arbiter.sv
// Round-robin arbiter feeding four requesters into one MD5 core.
// Issued requester ids are queued in a 4-deep tag FIFO so in-order digests
// can be routed back; each returned digest is compared against a target.
module md5_arbiter (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    md5_arbiter_if.master bus
);
    localparam int DATA_W = 128;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] tag_mem [0:3];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [2:0] tag_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] head_id;
    logic [1:0] grant;
    logic [1:0] cand;
    logic       grant_found;
    logic       issue;
    logic       pop;
    logic       orphan;
    logic       hit;

    assign tag_count  = wr_ptr - rd_ptr;
    assign fifo_full  = tag_count[2];
    assign fifo_empty = (tag_count == 3'd0);
    assign head_id    = tag_mem[rd_ptr[1:0]];
    assign bus.busy   = !fifo_empty;

    // Round-robin pick: first set request at or after ptr, wrapping
    always_comb begin
        grant       = 2'd0;
        grant_found = 1'b0;
        cand        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!grant_found && bus.req[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    // A registered core_msg_valid marks the cycle right after an issue, whose
    // core_ready and req are stale, so issuing is suppressed then. A full FIFO
    // blocks issue even when a pop happens in the same cycle.
    assign issue  = (state == RUN) && bus.core_ready && grant_found &&
                    !fifo_full && !bus.core_msg_valid;
    assign pop    = bus.core_out_valid && !fifo_empty;
    assign orphan = bus.core_out_valid && fifo_empty;
    assign hit    = pop && (bus.core_msg_out == bus.target) &&
                    (state == RUN) && !bus.match;

    // Control FSM; clear only releases HALT and overrides every other transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clear) begin
            if (state == HALT) state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (hit) state <= HALT;
                         else if (!enable) state <= IDLE;
                default: state <= HALT;
            endcase
        end
    end

    // Issue stage: registered grant, message hold and pointer advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr                <= 2'd0;
            bus.req_ack        <= 4'd0;
            bus.core_msg_valid <= 1'b0;
            bus.core_msg_in    <= '0;
            bus.core_msg_width <= 8'd0;
        end else begin
            bus.req_ack        <= 4'd0;
            bus.core_msg_valid <= issue;
            if (issue) begin
                bus.req_ack        <= 4'd1 << grant;
                bus.core_msg_in    <= bus.req_msg[{grant, 7'd0} +: DATA_W];
                bus.core_msg_width <= bus.req_width[{grant, 3'd0} +: 8];
                ptr                <= grant + 2'd1;
            end
        end
    end

    // Tag FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr[1:0]] <= grant;
    end

    // Tag FIFO pointers; reset drops every outstanding tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (issue) wr_ptr <= wr_ptr + 3'd1;
            if (pop)   rd_ptr <= rd_ptr + 3'd1;
        end
    end

    // Response stage: route each digest to the head-of-queue requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 2'd0;
            bus.rsp_digest <= '0;
        end else begin
            bus.rsp_valid <= pop;
            if (pop) begin
                bus.rsp_id     <= head_id;
                bus.rsp_digest <= bus.core_msg_out;
            end
        end
    end

    // Sticky match/error flags; clear wipes them, first hit owns match_id
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.match    <= 1'b0;
            bus.match_id <= 2'd0;
            bus.err      <= 1'b0;
        end else if (clear) begin
            bus.match    <= 1'b0;
            bus.match_id <= 2'd0;
            bus.err      <= 1'b0;
        end else begin
            if (hit) begin
                bus.match    <= 1'b1;
                bus.match_id <= head_id;
            end
            if (orphan) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_md5_arbiter.sv
// Bench for md5_arbiter: directed scenarios plus a randomized run, all
// compared every cycle against a queue-based behavioural model.
module tb_md5_arbiter;
    localparam logic [127:0] TGT = 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2;

    logic clk;
    logic reset;
    logic enable;
    logic clear;

    md5_arbiter_if bus ();

    md5_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;
    mstate_t      m_state;
    int           m_p;
    int           m_tags[$];
    bit           m_last;
    logic [3:0]   e_ack;
    bit           e_cmv;
    logic [127:0] e_cmi;
    logic [7:0]   e_cmw;
    bit           e_rspv;
    logic [1:0]   e_rspid;
    logic [127:0] e_rspd;
    bit           e_match;
    logic [1:0]   e_mid;
    bit           e_err;

    task automatic model_reset();
        m_state = M_IDLE; m_p = 0; m_tags.delete(); m_last = 0;
        e_ack = 0; e_cmv = 0; e_cmi = 0; e_cmw = 0;
        e_rspv = 0; e_rspid = 0; e_rspd = 0;
        e_match = 0; e_mid = 0; e_err = 0;
    endtask

    task automatic model_step();
        int g;
        int id;
        bit issue;
        bit hit;
        bit orphan;
        g = -1;
        id = 0;
        for (int k = 0; k < 4; k++)
            if (g < 0 && bus.req[(m_p + k) % 4]) g = (m_p + k) % 4;
        issue = (m_state == M_RUN) && bus.core_ready && (g >= 0) &&
                (m_tags.size() < 4) && !m_last;
        hit = 0;
        orphan = 0;
        e_ack = 0;
        e_rspv = 0;
        if (bus.core_out_valid) begin
            if (m_tags.size() > 0) begin
                id = m_tags.pop_front();
                e_rspv = 1;
                e_rspid = id[1:0];
                e_rspd = bus.core_msg_out;
                hit = (bus.core_msg_out == bus.target) && (m_state == M_RUN) && !e_match;
            end else begin
                orphan = 1;
            end
        end
        if (issue) begin
            e_ack = 4'(1 << g);
            e_cmi = bus.req_msg[128*g +: 128];
            e_cmw = bus.req_width[8*g +: 8];
            m_tags.push_back(g);
            m_p = (g + 1) % 4;
        end
        e_cmv = issue;
        m_last = issue;
        if (clear) begin
            e_match = 0; e_mid = 0; e_err = 0;
            if (m_state == M_HALT) m_state = M_IDLE;
        end else begin
            if (hit) begin e_match = 1; e_mid = id[1:0]; end
            if (orphan) e_err = 1;
            case (m_state)
                M_IDLE: if (enable) m_state = M_RUN;
                M_RUN:  if (hit) m_state = M_HALT; else if (!enable) m_state = M_IDLE;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack",       bus.req_ack,        e_ack);
            chk("msg_valid", bus.core_msg_valid, e_cmv);
            chk("msg_in",    bus.core_msg_in,    e_cmi);
            chk("msg_width", bus.core_msg_width, e_cmw);
            chk("rsp_valid", bus.rsp_valid,      e_rspv);
            chk("rsp_id",    bus.rsp_id,         e_rspid);
            chk("rsp_dig",   bus.rsp_digest,     e_rspd);
            chk("match",     bus.match,          e_match);
            chk("match_id",  bus.match_id,       e_mid);
            chk("err",       bus.err,            e_err);
            chk("busy",      bus.busy,           m_tags.size() != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 0; clear = 0;
        bus.req = 0; bus.core_ready = 0; bus.core_out_valid = 0;
        bus.core_msg_out = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic wait_ack(input string tag, input int budget, output logic [3:0] a);
        a = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (bus.req_ack != 0) begin
                a = bus.req_ack;
                return;
            end
        end
        chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},  bus.req_ack, 0);
        chk({tag, "_cmv"},  bus.core_msg_valid, 0);
        chk({tag, "_cmi"},  bus.core_msg_in, 0);
        chk({tag, "_cmw"},  bus.core_msg_width, 0);
        chk({tag, "_rspv"}, bus.rsp_valid, 0);
        chk({tag, "_rspi"}, bus.rsp_id, 0);
        chk({tag, "_rspd"}, bus.rsp_digest, 0);
        chk({tag, "_mt"},   bus.match, 0);
        chk({tag, "_mid"},  bus.match_id, 0);
        chk({tag, "_err"},  bus.err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a;
        int order[5];
        int when[5];
        int nacks;
        int cnum;
        int stray;

        reset = 1;
        idle_inputs();
        bus.req_msg = 0; bus.req_width = 0; bus.target = TGT;
        cyc();
        cyc();
        chk_on = 1;
        chk_all_zero("rst");
        reset = 0;

        for (int i = 0; i < 4; i++) begin
            bus.req_msg[128*i +: 128] = rand128();
            bus.req_width[8*i +: 8] = 8'(8 * (i + 1));
        end

        // round-robin with all requests held
        do_reset();
        enable = 1; bus.core_ready = 1; bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin order[i] = -1; when[i] = -1; end
        nacks = 0;
        cnum = 0;
        while (nacks < 5 && cnum < 60) begin
            cyc();
            cnum++;
            bus.core_out_valid = bus.core_msg_valid;
            bus.core_msg_out = rand128();
            if (bus.req_ack != 0) begin
                chk("rr_onehot", $countones(bus.req_ack), 1);
                for (int b = 0; b < 4; b++) if (bus.req_ack[b]) order[nacks] = b;
                when[nacks] = cnum;
                nacks++;
            end
        end
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), order[i], i % 4);
        for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), when[i] - when[i-1], 2);
        idle_inputs();
        cyc();

        // pointer wrap
        do_reset();
        enable = 1; bus.core_ready = 1; bus.req = 4'b0100;
        wait_ack("ptr_a", 10, a);
        chk("ptr_first", a, 4'b0100);
        bus.req = 4'b0101;
        wait_ack("ptr_b", 10, a);
        chk("ptr_wrap", a, 4'b0001);
        idle_inputs();

        // full tag FIFO blocks the fifth issue
        do_reset();
        enable = 1; bus.core_ready = 1; bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack("fill", 10, a);
            chk("fill_busy", bus.busy, 1);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.req_ack != 0) stray++;
            chk("full_busy", bus.busy, 1);
        end
        chk("full_noack", stray, 0);
        bus.core_out_valid = 1; bus.core_msg_out = rand128();
        cyc();
        bus.core_out_valid = 0;
        wait_ack("drain", 6, a);
        chk("after_pop_ack", a, 4'b0001);
        idle_inputs();

        // target match halts issuing; clear resumes
        do_reset();
        bus.target = TGT;
        enable = 1; bus.core_ready = 1; bus.req = 4'b0110;
        wait_ack("m1", 10, a);
        chk("m_grant1", a, 4'b0010);
        bus.req = 4'b0100;
        wait_ack("m2", 10, a);
        chk("m_grant2", a, 4'b0100);
        bus.req = 0;
        bus.core_out_valid = 1; bus.core_msg_out = rand128();
        cyc();
        chk("m_rsp1_id", bus.rsp_id, 1);
        chk("m_rsp1_match", bus.match, 0);
        bus.core_msg_out = TGT;
        cyc();
        bus.core_out_valid = 0;
        chk("m_rsp2_valid", bus.rsp_valid, 1);
        chk("m_rsp2_id", bus.rsp_id, 2);
        chk("m_hit", bus.match, 1);
        chk("m_hit_id", bus.match_id, 2);
        bus.req = 4'b1111;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.req_ack != 0) stray++;
        end
        chk("halt_noack", stray, 0);
        clear = 1;
        cyc();
        clear = 0;
        chk("clr_match", bus.match, 0);
        chk("clr_mid", bus.match_id, 0);
        wait_ack("resume", 10, a);
        chk("resume_ack", a, 4'b1000);
        idle_inputs();

        // digest with nothing outstanding
        do_reset();
        bus.core_out_valid = 1; bus.core_msg_out = rand128();
        cyc();
        bus.core_out_valid = 0;
        chk("orphan_err", bus.err, 1);
        chk("orphan_rsp", bus.rsp_valid, 0);
        cyc();
        chk("orphan_sticky", bus.err, 1);

        // asynchronous reset with two tags in flight
        do_reset();
        enable = 1; bus.core_ready = 1; bus.req = 4'b0011;
        wait_ack("ar1", 10, a);
        chk("ar_grant1", a, 4'b0001);
        bus.req = 4'b0010;
        wait_ack("ar2", 10, a);
        chk("ar_grant2", a, 4'b0010);
        idle_inputs();
        cyc();
        chk("ar_busy_before", bus.busy, 1);
        #2;
        reset = 1;
        #1;
        chk_all_zero("async_rst");
        cyc();
        reset = 0;
        bus.core_out_valid = 1; bus.core_msg_out = rand128();
        cyc();
        bus.core_out_valid = 0;
        chk("ar_err", bus.err, 1);
        chk("ar_rsp", bus.rsp_valid, 0);

        // randomized traffic against the model
        do_reset();
        bus.target = TGT;
        enable = 1;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            bus.req = bus.req & ~bus.req_ack;
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_msg[128*i +: 128] = rand128();
                    bus.req_width[8*i +: 8] = 8'($urandom_range(1, 128));
                end
            end
            bus.core_ready = ($urandom_range(0, 3) != 0);
            bus.core_out_valid = ($urandom_range(0, 2) == 0);
            bus.core_msg_out = ($urandom_range(0, 9) == 0) ? TGT : rand128();
            clear = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) enable = !enable;
        end
        idle_inputs();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
